// File: rtl/execute_stage_if.sv
// Execute-stage bus: ID/EX inputs, forwarding selects, the stall output
// and the EX/MEM pipeline register outputs.
interface execute_stage_if #(
    parameter int DATA_W = 16
);
    logic              in_valid;
    logic [3:0]        in_op;
    logic [2:0]        in_rd;
    logic              in_regwrite;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [DATA_W-1:0] imm;
    logic              use_imm;
    logic [1:0]        forward_A;
    logic [1:0]        forward_B;
    logic [DATA_W-1:0] ex_mem_result;
    logic [DATA_W-1:0] mem_wb_result;
    logic              flush;
    logic              stall;
    logic              out_valid;
    logic [2:0]        out_rd;
    logic              out_regwrite;
    logic [DATA_W-1:0] out_result;

    modport master (
        output in_valid, in_op, in_rd, in_regwrite, rs1_data, rs2_data, imm,
               use_imm, forward_A, forward_B, ex_mem_result, mem_wb_result, flush,
        input  stall, out_valid, out_rd, out_regwrite, out_result
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_regwrite, rs1_data, rs2_data, imm,
               use_imm, forward_A, forward_B, ex_mem_result, mem_wb_result, flush,
        output stall, out_valid, out_rd, out_regwrite, out_result
    );
endinterface

// File: rtl/execute_stage.sv
// EX stage: forwarded operand select, single-cycle ALU, iterative
// shift-add multiplier that stalls upstream, and the EX/MEM register.
module execute_stage #(
    parameter int DATA_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    execute_stage_if.slave  bus
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLL = 4'd5;
    localparam logic [3:0] OP_SRL = 4'd6;
    localparam logic [3:0] OP_SLT = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;

    typedef enum logic {IDLE, MUL_BUSY} state_t;

    state_t            state, state_next;
    logic [DATA_W-1:0] op_a, op_b, alu_result;
    logic [DATA_W-1:0] mul_a, mul_b, acc, acc_step;
    logic [CNT_W-1:0]  count;
    logic [2:0]        mul_rd;
    logic              mul_regwrite;
    logic              accept, issue, busy_stall;

    assign accept   = bus.in_valid && !bus.flush;
    assign issue    = (state == IDLE) && accept && (bus.in_op == OP_MUL);
    assign acc_step = mul_b[0] ? (acc + mul_a) : acc;
    assign bus.stall = rst_n && busy_stall;

    // Operand select: forwarding code 11 falls back to the register file.
    always_comb begin
        case (bus.forward_A)
            2'b01:   op_a = bus.mem_wb_result;
            2'b10:   op_a = bus.ex_mem_result;
            default: op_a = bus.rs1_data;
        endcase
        if (bus.use_imm) begin
            op_b = bus.imm;
        end else begin
            case (bus.forward_B)
                2'b01:   op_b = bus.mem_wb_result;
                2'b10:   op_b = bus.ex_mem_result;
                default: op_b = bus.rs2_data;
            endcase
        end
    end

    // Single-cycle ALU; MUL and NOP produce nothing here.
    always_comb begin
        alu_result = '0;
        case (bus.in_op)
            OP_ADD: alu_result = op_a + op_b;
            OP_SUB: alu_result = op_a - op_b;
            OP_AND: alu_result = op_a & op_b;
            OP_OR:  alu_result = op_a | op_b;
            OP_XOR: alu_result = op_a ^ op_b;
            OP_SLL: alu_result = op_a << op_b[3:0];
            OP_SRL: alu_result = op_a >> op_b[3:0];
            OP_SLT: alu_result = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            default: alu_result = '0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and stall: stall drops on the final multiply cycle so upstream advances with the product.
    always_comb begin
        state_next = state;
        busy_stall = 1'b0;
        case (state)
            IDLE: begin
                if (issue) begin
                    state_next = MUL_BUSY;
                    busy_stall = 1'b1;
                end
            end
            MUL_BUSY: begin
                if (bus.flush || (count == CNT_W'(1))) begin
                    state_next = IDLE;
                end else begin
                    busy_stall = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Multiplier datapath and EX/MEM register; a bubble clears valid/rd/regwrite but keeps the result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.out_valid    <= 1'b0;
            bus.out_rd       <= '0;
            bus.out_regwrite <= 1'b0;
            bus.out_result   <= '0;
            mul_a            <= '0;
            mul_b            <= '0;
            acc              <= '0;
            count            <= '0;
            mul_rd           <= '0;
            mul_regwrite     <= 1'b0;
        end else begin
            bus.out_valid    <= 1'b0;
            bus.out_rd       <= '0;
            bus.out_regwrite <= 1'b0;
            if (state == IDLE) begin
                if (issue) begin
                    mul_a        <= op_a;
                    mul_b        <= op_b;
                    acc          <= '0;
                    count        <= CNT_W'(DATA_W);
                    mul_rd       <= bus.in_rd;
                    mul_regwrite <= bus.in_regwrite && (bus.in_rd != 3'd0);
                end else if (accept) begin
                    bus.out_valid    <= 1'b1;
                    bus.out_rd       <= bus.in_rd;
                    bus.out_regwrite <= bus.in_regwrite && (bus.in_rd != 3'd0) && (bus.in_op <= OP_MUL);
                    bus.out_result   <= alu_result;
                end
            end else if (!bus.flush) begin
                acc   <= acc_step;
                mul_a <= mul_a << 1;
                mul_b <= mul_b >> 1;
                count <= count - CNT_W'(1);
                if (count == CNT_W'(1)) begin
                    bus.out_valid    <= 1'b1;
                    bus.out_rd       <= mul_rd;
                    bus.out_regwrite <= mul_regwrite;
                    bus.out_result   <= acc_step;
                end
            end
        end
    end
endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- EX stage of the 8-register pipelined core, directly downstream of the RAW forwarding unit.
- Consumes forward_A/forward_B to select each ALU operand from the register file, the EX/MEM result or the MEM/WB result.
- Runs single-cycle ALU ops and an iterative shift-add multiply; while the multiply runs it stalls upstream.
- Owns the EX/MEM pipeline register whose rd/regwrite/result fields feed back to the forwarding unit.

Parameters:
DATA_W, 16, datapath width in bits; also the multiply iteration count.

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  an instruction currently occupies ID/EX
in_op  input  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SLT (signed), 8 MUL, 9-15 NOP
in_rd  input  3  destination register
in_regwrite  input  1  instruction writes rd
rs1_data  input  DATA_W  register-file value of rs1
rs2_data  input  DATA_W  register-file value of rs2
imm  input  DATA_W  sign-extended immediate
use_imm  input  1  operand B = imm instead of forwarded rs2
forward_A  input  2  00 rs1_data, 01 mem_wb_result, 10 ex_mem_result, 11 treated as 00
forward_B  input  2  same encoding for rs2
ex_mem_result  input  DATA_W  value currently in EX/MEM (out_result fed back)
mem_wb_result  input  DATA_W  value being written back
flush  input  1  discard instruction in EX (branch redirect)
stall  output  1  hold ID/EX and earlier stages this cycle
out_valid  output  1  EX/MEM valid
out_rd  output  3  EX/MEM destination
out_regwrite  output  1  EX/MEM write enable
out_result  output  DATA_W  EX/MEM result

Behaviour:
- Reset (rst_n=0 at edge): state IDLE, out_valid=0, out_rd=0, out_regwrite=0, out_result=0, multiply registers 0. stall is combinational and 0 while rst_n=0. Reset mid-multiply aborts it with no output.
- Operand select (combinational, IDLE only):
  - A = mux(forward_A).
  - B = imm if use_imm, else mux(forward_B).
- States: IDLE, MUL_BUSY.
- IDLE, in_valid=1, flush=0, op≠MUL: at the next edge out_* load the result; latency 1.
  - out_regwrite = in_regwrite && in_rd≠0 && op≤8.
  - NOP loads out_valid=1 with out_regwrite=0.
- IDLE, in_valid=0 or flush=1: next edge loads a bubble: out_valid=0, out_regwrite=0, out_rd=0, out_result holds.
- Arithmetic (all DATA_W-bit, results truncated):
  - ADD/SUB wrap modulo 2^DATA_W.
  - SLL/SRL (logical) shift by B[3:0].
  - SLT yields 1 or 0 by signed compare.
  - MUL yields the low DATA_W bits of the product.
- MUL issue (IDLE, in_valid, op=8, flush=0) in cycle T:
  - Latches A, B, rd and regwrite; clears the accumulator.
  - Counter = DATA_W; goes to MUL_BUSY; stall=1 in cycle T.
  - The next edge loads a bubble into EX/MEM.
- MUL_BUSY: each cycle one shift-add step, counter decrements.
  - stall=1 in every busy cycle except the last (counter=1), so upstream advances at the completing edge.
  - in_*, forward_* and rs*_data are ignored in this state.
  - EX/MEM holds a bubble until the completing edge, which loads the product (out_valid=1); state returns to IDLE.
  - Product visible in cycle T+DATA_W+1.
- flush during MUL_BUSY: abort, IDLE at the next edge, EX/MEM bubble, stall=0 that cycle. flush in IDLE suppresses any issue, including MUL.
- stall = (IDLE && in_valid && op=8 && !flush) || (MUL_BUSY && counter>1 && !flush).
- Simultaneous flush and rst_n=0: reset wins.

Test Plan:
1. Reset: rst_n=0 for 2 cycles with in_valid=1 ADD -> all out_* 0, stall=0 throughout.
2. Forwarding: rs1_data=5, ex_mem_result=7, mem_wb_result=9, rs2_data=3, forward_A=10, forward_B=01, ADD rd=2 -> next cycle out_result=16, out_rd=2, out_regwrite=1. Repeat with forward_A=11 -> 14.
3. Edge ops, all next cycle:
   - SUB 0-1 -> 0xFFFF.
   - SLT 0xFFFF vs 1 -> 1.
   - SLL 1 by B=0x0013 -> 0x0008.
   - rd=0 ADD -> out_regwrite=0.
4. MUL: issue 300*7 at T with DATA_W=16 -> stall high T..T+15, low at T+16; out_valid=0 T+1..T+16; out_result=2100, out_valid=1 at T+17. A changing forward_A during busy has no effect. MUL 0x0100*0x0100 -> 0.
5. Flush: flush at T+5 of a MUL -> stall=0 that cycle, IDLE next, no product ever emitted; flush with an ADD in IDLE -> bubble.
6. Back-to-back: ADD, MUL, ADD presented with the stall protocol honoured -> out sequence ADD result, DATA_W bubbles, product, ADD result, each exactly once.
